// File: rtl/regfile_write_scoreboard_pkg.sv
// Shared constants and the index-to-one-hot helper for the register-file
// write-enable decoder and outstanding-write scoreboard.
package regfile_write_scoreboard_pkg;

    localparam int unsigned REG_ZERO         = 0;
    localparam int unsigned DEFAULT_NUM_REGS = 32;
    localparam int unsigned DEFAULT_CNT_W    = 2;

    // Widest index the helper accepts; callers cast the result down to NUM_REGS bits.
    localparam int unsigned MAX_ADDR_W = 8;
    localparam int unsigned MAX_REGS   = 1 << MAX_ADDR_W;

    function automatic logic [MAX_REGS-1:0] oneHot(input logic [MAX_ADDR_W-1:0] idx);
        oneHot = MAX_REGS'(1) << idx;
    endfunction

endpackage

// File: rtl/regfile_wen_decode.sv
// WB_PORTS-to-one-hot OR decoder; exposes the per-port one-hot terms so the
// scoreboard can count how many ports retire each register.
module regfile_wen_decode
    import regfile_write_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_REGS       = DEFAULT_NUM_REGS,
    parameter int unsigned WB_PORTS       = 1,
    parameter bit          ZERO_HARDWIRED = 1'b1,
    localparam int unsigned ADDR_W        = $clog2(NUM_REGS)
) (
    input  logic [WB_PORTS-1:0]               wbValid,
    input  logic [WB_PORTS*ADDR_W-1:0]        wbRd,
    output logic [WB_PORTS-1:0][NUM_REGS-1:0] portHit_c,
    output logic [NUM_REGS-1:0]               writeEn_c
);

    localparam logic [NUM_REGS-1:0] KEEP_MASK =
        ZERO_HARDWIRED ? ~(NUM_REGS'(1) << REG_ZERO) : '1;

    always_comb begin
        writeEn_c = '0;
        portHit_c = '0;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (wbValid[p]) begin
                portHit_c[p] = NUM_REGS'(oneHot(MAX_ADDR_W'(wbRd[p*ADDR_W +: ADDR_W]))) & KEEP_MASK;
            end
            writeEn_c = writeEn_c | portHit_c[p];
        end
    end

endmodule

// File: rtl/regfile_write_scoreboard.sv
// Register-file write-enable decode plus per-register outstanding-write
// counters that give the ID stage busy/hazard status for stall decisions.
module regfile_write_scoreboard
    import regfile_write_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_REGS       = DEFAULT_NUM_REGS,
    parameter int unsigned WB_PORTS       = 1,
    parameter int unsigned CNT_W          = DEFAULT_CNT_W,
    parameter bit          ZERO_HARDWIRED = 1'b1,
    localparam int unsigned ADDR_W        = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       issue_valid,
    input  logic [ADDR_W-1:0]          issue_rd,
    output logic                       issue_ready,
    input  logic [WB_PORTS-1:0]        wb_valid,
    input  logic [WB_PORTS*ADDR_W-1:0] wb_rd,
    output logic [NUM_REGS-1:0]        write_en,
    input  logic [ADDR_W-1:0]          q_rs,
    input  logic [ADDR_W-1:0]          q_rt,
    output logic                       hazard_rs,
    output logic                       hazard_rt,
    output logic [NUM_REGS-1:0]        busy,
    input  logic                       flush,
    output logic                       err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]                  cnt     [NUM_REGS];
    logic [CNT_W-1:0]                  cntNext [NUM_REGS];
    logic                              errNext;
    logic [WB_PORTS-1:0][NUM_REGS-1:0] portHit;
    logic [NUM_REGS-1:0]               issueHit;
    logic                              issueAccept;
    int unsigned                       decV;
    int unsigned                       sumV;

    regfile_wen_decode #(
        .NUM_REGS       (NUM_REGS),
        .WB_PORTS       (WB_PORTS),
        .ZERO_HARDWIRED (ZERO_HARDWIRED)
    ) uDecode (
        .wbValid   (wb_valid),
        .wbRd      (wb_rd),
        .portHit_c (portHit),
        .writeEn_c (write_en)
    );

    // A full counter only blocks issue when no writeback frees a slot this cycle.
    assign issue_ready = !(issue_valid && (cnt[issue_rd] == CNT_MAX) && !write_en[issue_rd]);
    assign issueAccept = issue_valid && issue_ready;
    assign issueHit    = issueAccept ? NUM_REGS'(oneHot(MAX_ADDR_W'(issue_rd))) : '0;

    // Per-register net update; underflow floors at zero and flags a protocol error.
    always_comb begin
        errNext = err;
        decV    = 0;
        sumV    = 0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            decV = 0;
            for (int unsigned p = 0; p < WB_PORTS; p++) begin
                decV = decV + 32'(portHit[p][i]);
            end
            sumV = 32'(cnt[i]) + 32'(issueHit[i]);
            if (ZERO_HARDWIRED && (i == REG_ZERO)) begin
                cntNext[i] = '0;
            end else begin
                if (decV > sumV) begin
                    cntNext[i] = '0;
                    errNext    = 1'b1;
                end else begin
                    cntNext[i] = CNT_W'(sumV - decV);
                end
                if ((decV > 1) && (i != REG_ZERO)) begin
                    errNext = 1'b1;
                end
            end
            if (flush) begin
                cntNext[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                cnt[i] <= '0;
            end
            err <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                cnt[i] <= cntNext[i];
            end
            err <= errNext;
        end
    end

    always_comb begin
        busy = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            busy[i] = |cnt[i];
        end
    end

    assign hazard_rs = busy[q_rs];
    assign hazard_rt = busy[q_rt];

endmodule

// File: tb/tb_regfile_write_scoreboard.sv
// Directed plus randomized bench for regfile_write_scoreboard against an
// integer-count reference model of outstanding writes.
module tb_regfile_write_scoreboard;

    localparam int unsigned NR   = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned WP   = 2;
    localparam int unsigned CW   = 2;
    localparam int          CMAX = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          iv;
    logic [AW-1:0] ird;
    logic          ready;
    logic [WP-1:0] wbv;
    logic [WP*AW-1:0] wbrd;
    logic [NR-1:0] wen;
    logic [AW-1:0] qrs;
    logic [AW-1:0] qrt;
    logic          hzs;
    logic          hzt;
    logic [NR-1:0] busy;
    logic          flush;
    logic          err;

    int mcnt [NR];
    bit merr;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_write_scoreboard #(
        .NUM_REGS       (NR),
        .WB_PORTS       (WP),
        .CNT_W          (CW),
        .ZERO_HARDWIRED (1'b1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .issue_valid (iv),
        .issue_rd    (ird),
        .issue_ready (ready),
        .wb_valid    (wbv),
        .wb_rd       (wbrd),
        .write_en    (wen),
        .q_rs        (qrs),
        .q_rt        (qrt),
        .hazard_rs   (hzs),
        .hazard_rt   (hzt),
        .busy        (busy),
        .flush       (flush),
        .err         (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] modelBusy();
        logic [31:0] b = '0;
        for (int r = 0; r < NR; r++) b[r] = (mcnt[r] != 0);
        return b;
    endfunction

    task automatic checkState(input string tag);
        logic [31:0] b;
        b = modelBusy();
        check({tag, ".busy"}, busy, b);
        check({tag, ".err"}, 32'(err), 32'(merr));
        check({tag, ".hzs"}, 32'(hzs), 32'(b[qrs]));
        check({tag, ".hzt"}, 32'(hzt), 32'(b[qrt]));
    endtask

    // One clock: drive inputs, check combinational outputs, advance model, check registered state.
    task automatic cycle(input string tag, input bit v, input int rd,
                         input bit [1:0] wv, input int r0, input int r1, input bit fl);
        logic [31:0] wexp;
        bit hit, rexp;
        int n, inc;
        iv    = v;
        ird   = 5'(rd);
        wbv   = wv;
        wbrd  = {5'(r1), 5'(r0)};
        flush = fl;
        #1;
        wexp = '0;
        if (wv[0] && r0 != 0) wexp[r0] = 1'b1;
        if (wv[1] && r1 != 0) wexp[r1] = 1'b1;
        hit  = (wv[0] && r0 == rd) || (wv[1] && r1 == rd);
        rexp = !(v && mcnt[rd] == CMAX && !hit);
        check({tag, ".wen"}, wen, wexp);
        check({tag, ".ready"}, 32'(ready), 32'(rexp));
        checkState({tag, ".pre"});
        for (int r = 1; r < NR; r++) begin
            n   = int'(wv[0] && r0 == r) + int'(wv[1] && r1 == r);
            inc = int'(v && rexp && rd == r);
            if (n > 1) merr = 1'b1;
            if (n > mcnt[r] + inc) begin
                merr    = 1'b1;
                mcnt[r] = 0;
            end else begin
                mcnt[r] = mcnt[r] + inc - n;
            end
        end
        if (fl) for (int r = 0; r < NR; r++) mcnt[r] = 0;
        @(posedge clk);
        #1;
        iv    = 1'b0;
        wbv   = '0;
        flush = 1'b0;
        checkState({tag, ".post"});
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, 0, 2'b00, 0, 0, 1'b0);
    endtask

    // Reset pulse placed between clock edges; clears must be visible before the next edge.
    task automatic asyncResetPulse(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        for (int r = 0; r < NR; r++) mcnt[r] = 0;
        merr = 1'b0;
        checkState(tag);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        iv = 1'b0; ird = '0; wbv = '0; wbrd = '0; flush = 1'b0;
        qrs = 5'd5; qrt = 5'd7;
        for (int r = 0; r < NR; r++) mcnt[r] = 0;
        merr = 1'b0;
        #12;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkState("reset");
        check("reset.ready", 32'(ready), 32'd1);

        cycle("wb_r0", 1'b0, 0, 2'b01, 0, 0, 1'b0);

        // Basic RAW on r5
        cycle("issue5", 1'b1, 5, 2'b00, 0, 0, 1'b0);
        check("raw.hzs", 32'(hzs), 32'd1);
        idle("raw.idle1");
        idle("raw.idle2");
        cycle("wb5", 1'b0, 0, 2'b01, 5, 0, 1'b0);
        check("raw.busy5", 32'(busy[5]), 32'd0);

        // Saturation on r7
        for (int k = 0; k < 3; k++) cycle("sat.issue", 1'b1, 7, 2'b00, 0, 0, 1'b0);
        cycle("sat.reject", 1'b1, 7, 2'b00, 0, 0, 1'b0);
        cycle("sat.issue_wb", 1'b1, 7, 2'b01, 7, 0, 1'b0);
        cycle("sat.wb_a", 1'b0, 0, 2'b01, 7, 0, 1'b0);
        cycle("sat.wb_b", 1'b0, 0, 2'b10, 0, 7, 1'b0);
        check("sat.still_busy", 32'(busy[7]), 32'd1);
        cycle("sat.wb_c", 1'b0, 0, 2'b01, 7, 0, 1'b0);

        // Simultaneous issue and writeback on two ports
        qrs = 5'd9; qrt = 5'd4;
        cycle("sim.issue9", 1'b1, 9, 2'b00, 0, 0, 1'b0);
        cycle("sim.issue4", 1'b1, 4, 2'b00, 0, 0, 1'b0);
        cycle("sim.both", 1'b1, 9, 2'b11, 9, 4, 1'b0);
        check("sim.busy9", 32'(busy[9]), 32'd1);
        check("sim.busy4", 32'(busy[4]), 32'd0);

        // Underflow error, sticky through flush
        qrs = 5'd12;
        cycle("err.wb12", 1'b0, 0, 2'b01, 12, 0, 1'b0);
        check("err.set", 32'(err), 32'd1);
        qrs = 5'd3; qrt = 5'd8;
        cycle("fl.issue3", 1'b1, 3, 2'b00, 0, 0, 1'b0);
        cycle("fl.issue8", 1'b1, 8, 2'b00, 0, 0, 1'b0);
        cycle("fl.flush", 1'b1, 3, 2'b00, 0, 0, 1'b1);
        check("fl.allclear", busy, 32'd0);
        check("fl.err_kept", 32'(err), 32'd1);

        // Async reset mid-sequence
        cycle("ar.issue10", 1'b1, 10, 2'b00, 0, 0, 1'b0);
        asyncResetPulse("ar.pulse1");

        // Duplicate writeback without underflow
        qrs = 5'd15;
        cycle("dup.issue_a", 1'b1, 15, 2'b00, 0, 0, 1'b0);
        cycle("dup.issue_b", 1'b1, 15, 2'b00, 0, 0, 1'b0);
        cycle("dup.wb", 1'b0, 0, 2'b11, 15, 15, 1'b0);
        check("dup.err", 32'(err), 32'd1);
        asyncResetPulse("dup.pulse");

        // Randomized traffic on a small register window to provoke collisions
        for (int c = 0; c < 400; c++) begin
            bit v, fl;
            bit [1:0] wv;
            v   = ($urandom_range(0, 9) < 6);
            wv  = 2'($urandom_range(0, 3));
            fl  = ($urandom_range(0, 24) == 0);
            qrs = 5'($urandom_range(0, 7));
            qrt = 5'($urandom_range(0, 7));
            cycle("rnd", v, int'($urandom_range(0, 7)), wv,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), fl);
            if ((c % 50) == 49) asyncResetPulse("rnd.pulse");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
